dcache_axi_line: RTL and testbench
==================================

DCACHE_AXI_LINE -- requirements
Module: dcache_axi_line

Interface
REQ-001 SHALL have parameter AXI_ID, default 4'd0, ID driven on every request.
REQ-002 SHALL have clk input 1 clock; all logic on rising edge; one clock domain.
REQ-003 SHALL have rst input 1 asynchronous active-high reset.
REQ-004 SHALL have fill_req_i input 1 request a line refill at req_addr_i.
REQ-005 SHALL have evict_req_i input 1 request a line writeback of evict_data_i to req_addr_i.
REQ-006 SHALL have req_addr_i input 32 line address; bits [4:0] ignored and driven as zero.
REQ-007 SHALL have evict_data_i input 256 line data; word n = bits [32n+31:32n].
REQ-008 SHALL have req_ready_o output 1 high in IDLE only; request is taken when ready and either request bit is high.
REQ-009 SHALL have fill_valid_o output 1 one-cycle pulse when fill_data_o holds a complete line.
REQ-010 SHALL have fill_data_o output 256 assembled refill line, same word order as evict_data_i.
REQ-011 SHALL have evict_done_o output 1 one-cycle pulse on write-response receipt.
REQ-012 SHALL have err_o output 1 one-cycle pulse with fill_valid_o/evict_done_o when any bresp/rresp was non-zero.
REQ-013 SHALL have mem_valid_o output 1 downstream request valid.
REQ-014 SHALL have mem_write_o output 1 1 = write burst, 0 = read.
REQ-015 SHALL have mem_addr_o output 32 line-aligned burst address.
REQ-016 SHALL have mem_id_o output 4 equals AXI_ID.
REQ-017 SHALL have mem_len_o output 8 constant 8'd7.
REQ-018 SHALL have mem_burst_o output 2 constant 2'b01 (INCR).
REQ-019 SHALL have mem_wdata_o output 32 current write beat word.
REQ-020 SHALL have mem_wstrb_o output 4 4'hF on writes, 4'h0 on reads.
REQ-021 SHALL have mem_accept_i input 1 downstream consumed current beat/request.
REQ-022 SHALL have mem_bvalid_i input 1 write response valid.
REQ-023 SHALL have mem_bresp_i input 2 write response code.
REQ-024 SHALL have mem_bready_o output 1 write response ready.
REQ-025 SHALL have mem_rvalid_i input 1 read data valid.
REQ-026 SHALL have mem_rdata_i input 32 read data word.
REQ-027 SHALL have mem_rresp_i input 2 read response code.
REQ-028 SHALL have mem_rlast_i input 1 final read beat.
REQ-029 SHALL have mem_rready_o output 1 read data ready.

Function
REQ-030 SHALL use FSM IDLE, WR_DATA, WR_RESP, RD_ADDR, RD_DATA.
REQ-031 SHALL give evict priority over fill when both are requested in the same cycle; fill is ignored, not queued.
REQ-032 SHALL on evict accept capture address and evict_data_i, clear 3-bit beat counter, go to WR_DATA.
REQ-033 SHALL in WR_DATA hold mem_valid_o=1, mem_write_o=1, wdata=word[beat]; each mem_accept_i increments beat; accept at beat 7 goes to WR_RESP.
REQ-034 SHALL hold all mem_* request fields stable while mem_valid_o=1 and mem_accept_i=0.
REQ-035 SHALL in WR_RESP drive mem_bready_o=1; bvalid pulses evict_done_o next cycle and returns to IDLE.
REQ-036 SHALL on fill accept go to RD_ADDR, mem_valid_o=1, mem_write_o=0, until mem_accept_i, then RD_DATA.
REQ-037 SHALL in RD_DATA drive mem_rready_o=1, store each rvalid beat at word[beat], increment beat; rvalid with rlast pulses fill_valid_o next cycle, back to IDLE.
REQ-038 SHALL accumulate a sticky error flag over all responses of a transaction, cleared on accept.
REQ-039 SHALL treat rlast before beat 7 as end of line (err_o set) and ignore rvalid outside RD_DATA.
REQ-040 SHALL keep mem_bready_o/mem_rready_o low outside their states.

Reset
REQ-041 SHALL on rst force IDLE, counters/flags zero, all outputs zero except mem_len_o=7, mem_burst_o=1, mem_id_o=AXI_ID; mid-burst reset abandons the burst with no done pulse.

Structure
REQ-042 SHALL place LINE_WORDS=8, burst-type and response-code constants in shared package dcache_pkg.
REQ-043 SHALL be a single module with no sub-modules; the line buffer is a flop array shared by fill and evict.

Verification
REQ-044 SHALL cover evict of words 0x0..0x7, accept always high -> 8 beats in order, one evict_done_o, err_o=0.
REQ-045 SHALL cover evict with accept stalled 3 cycles on beat 4 -> wdata held at word 4, no beat lost.
REQ-046 SHALL cover fill at 0x8000_0010 -> mem_addr_o=0x8000_0000, len=7; rdata 0xA0..0xA7 -> fill_data_o matches, one pulse.
REQ-047 SHALL cover simultaneous fill and evict -> evict only; rresp=2 on beat 3 of a later fill -> err_o with fill_valid_o.
REQ-048 SHALL cover rst asserted during WR_DATA beat 5 -> IDLE, mem_valid_o=0, no evict_done_o.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared constants and types for the data-cache line refill/writeback engine.
package dcache_pkg;

  // Line geometry: eight 32-bit words per 32-byte cache line.
  localparam int LINE_WORDS = 8;
  localparam int WORD_W     = 32;
  localparam int LINE_W     = LINE_WORDS * WORD_W;
  localparam int BEAT_W     = 3;
  localparam int OFFSET_W   = 5;

  // Index of the final beat in a full-line burst.
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  // Burst length field is "beats minus one".
  localparam logic [7:0] BURST_LEN = 8'(LINE_WORDS - 1);

  // Burst type encodings.
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Response code encodings.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Engine states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_DATA = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4
  } state_t;

  // Drops the byte offset within a line so bursts always start on a line boundary.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return {addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

  // Anything other than a plain OKAY is reported upward as an error.
  function automatic logic resp_is_error(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/dcache_axi_line.sv
// Moves one cache line between the data cache and an AXI-style memory port:
// an eviction writes the line as an 8-beat INCR burst, a fill reads one back.
module dcache_axi_line
  import dcache_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fill_req_i,
  input  logic                evict_req_i,
  input  logic [31:0]         req_addr_i,
  input  logic [LINE_W-1:0]   evict_data_i,
  output logic                req_ready_o,
  output logic                fill_valid_o,
  output logic [LINE_W-1:0]   fill_data_o,
  output logic                evict_done_o,
  output logic                err_o,
  output logic                mem_valid_o,
  output logic                mem_write_o,
  output logic [31:0]         mem_addr_o,
  output logic [3:0]          mem_id_o,
  output logic [7:0]          mem_len_o,
  output logic [1:0]          mem_burst_o,
  output logic [WORD_W-1:0]   mem_wdata_o,
  output logic [3:0]          mem_wstrb_o,
  input  logic                mem_accept_i,
  input  logic                mem_bvalid_i,
  input  logic [1:0]          mem_bresp_i,
  output logic                mem_bready_o,
  input  logic                mem_rvalid_i,
  input  logic [WORD_W-1:0]   mem_rdata_i,
  input  logic [1:0]          mem_rresp_i,
  input  logic                mem_rlast_i,
  output logic                mem_rready_o
);

  state_t              state_q;
  state_t              state_d;
  logic [31:0]         addr_q;
  logic [WORD_W-1:0]   line_q [LINE_WORDS];
  logic [BEAT_W-1:0]   beat_q;
  logic                err_q;
  logic                fill_valid_q;
  logic                evict_done_q;
  logic                err_pulse_q;

  logic                idle;
  logic                take_evict;
  logic                take_fill;
  logic                wr_beat_done;
  logic                wr_last_beat;
  logic                rd_addr_done;
  logic                b_handshake;
  logic                r_handshake;
  logic                r_final;
  logic                rd_beat_err;
  logic                b_err;

  // Request acceptance: an eviction always wins, a simultaneous fill is dropped.
  assign idle         = (state_q == ST_IDLE);
  assign take_evict   = idle && evict_req_i;
  assign take_fill    = idle && fill_req_i && !evict_req_i;

  // Handshake qualifiers, each only meaningful in its own state.
  assign wr_beat_done = (state_q == ST_WR_DATA) && mem_accept_i;
  assign wr_last_beat = wr_beat_done && (beat_q == LAST_BEAT);
  assign rd_addr_done = (state_q == ST_RD_ADDR) && mem_accept_i;
  assign b_handshake  = (state_q == ST_WR_RESP) && mem_bvalid_i;
  assign r_handshake  = (state_q == ST_RD_DATA) && mem_rvalid_i;
  assign r_final      = r_handshake && mem_rlast_i;

  // A read beat is bad if its response is bad, if the burst ends short,
  // or if the memory keeps streaming past the last word of the line.
  assign rd_beat_err  = resp_is_error(mem_rresp_i)
                      || (mem_rlast_i && (beat_q != LAST_BEAT))
                      || (!mem_rlast_i && (beat_q == LAST_BEAT));
  assign b_err        = resp_is_error(mem_bresp_i);

  // State register; reset abandons any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection and the per-state handshake outputs.
  always_comb begin
    state_d      = state_q;
    mem_valid_o  = 1'b0;
    mem_write_o  = 1'b0;
    mem_wstrb_o  = 4'h0;
    mem_wdata_o  = '0;
    mem_bready_o = 1'b0;
    mem_rready_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (take_evict) begin
          state_d = ST_WR_DATA;
        end else if (take_fill) begin
          state_d = ST_RD_ADDR;
        end
      end
      ST_WR_DATA: begin
        mem_valid_o = 1'b1;
        mem_write_o = 1'b1;
        mem_wstrb_o = 4'hF;
        mem_wdata_o = line_q[beat_q];
        if (wr_last_beat) begin
          state_d = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        mem_bready_o = 1'b1;
        if (b_handshake) begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        mem_valid_o = 1'b1;
        if (rd_addr_done) begin
          state_d = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        mem_rready_o = 1'b1;
        if (r_final) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Line buffer, beat counter, sticky error and the completion pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      beat_q       <= '0;
      err_q        <= 1'b0;
      fill_valid_q <= 1'b0;
      evict_done_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      for (int i = 0; i < LINE_WORDS; i++) begin
        line_q[i] <= '0;
      end
    end else begin
      fill_valid_q <= 1'b0;
      evict_done_q <= 1'b0;
      err_pulse_q  <= 1'b0;

      if (take_evict) begin
        addr_q <= line_align(req_addr_i);
        beat_q <= '0;
        err_q  <= 1'b0;
        for (int i = 0; i < LINE_WORDS; i++) begin
          line_q[i] <= evict_data_i[i*WORD_W +: WORD_W];
        end
      end else if (take_fill) begin
        addr_q <= line_align(req_addr_i);
        beat_q <= '0;
        err_q  <= 1'b0;
      end

      if (wr_beat_done) begin
        beat_q <= beat_q + 1'b1;
      end

      if (b_handshake) begin
        err_q        <= err_q || b_err;
        evict_done_q <= 1'b1;
        err_pulse_q  <= err_q || b_err;
      end

      if (r_handshake) begin
        line_q[beat_q] <= mem_rdata_i;
        beat_q         <= beat_q + 1'b1;
        err_q          <= err_q || rd_beat_err;
        if (mem_rlast_i) begin
          fill_valid_q <= 1'b1;
          err_pulse_q  <= err_q || rd_beat_err;
        end
      end
    end
  end

  // Present the line buffer as a flat vector, word 0 in the low bits.
  for (genvar g = 0; g < LINE_WORDS; g++) begin : g_fill_data
    assign fill_data_o[g*WORD_W +: WORD_W] = line_q[g];
  end

  // Held ready is masked during reset so every handshake output reads zero then.
  assign req_ready_o  = idle && !rst;
  assign fill_valid_o = fill_valid_q;
  assign evict_done_o = evict_done_q;
  assign err_o        = err_pulse_q;
  assign mem_addr_o   = addr_q;
  assign mem_id_o     = AXI_ID;
  assign mem_len_o    = BURST_LEN;
  assign mem_burst_o  = BURST_INCR;

endmodule

// File: tb/tb_dcache_axi_line.sv
// Scoreboard bench for dcache_axi_line: tasks act as the cache and the memory,
// a negedge monitor checks every handshake against queued expectations.
module tb_dcache_axi_line;

  localparam logic [3:0] TB_ID = 4'd5;

  logic         clk;
  logic         rst;
  logic         fill_req_i;
  logic         evict_req_i;
  logic [31:0]  req_addr_i;
  logic [255:0] evict_data_i;
  logic         req_ready_o;
  logic         fill_valid_o;
  logic [255:0] fill_data_o;
  logic         evict_done_o;
  logic         err_o;
  logic         mem_valid_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [3:0]   mem_id_o;
  logic [7:0]   mem_len_o;
  logic [1:0]   mem_burst_o;
  logic [31:0]  mem_wdata_o;
  logic [3:0]   mem_wstrb_o;
  logic         mem_accept_i;
  logic         mem_bvalid_i;
  logic [1:0]   mem_bresp_i;
  logic         mem_bready_o;
  logic         mem_rvalid_i;
  logic [31:0]  mem_rdata_i;
  logic [1:0]   mem_rresp_i;
  logic         mem_rlast_i;
  logic         mem_rready_o;

  dcache_axi_line #(.AXI_ID(TB_ID)) dut (
    .clk          (clk),
    .rst          (rst),
    .fill_req_i   (fill_req_i),
    .evict_req_i  (evict_req_i),
    .req_addr_i   (req_addr_i),
    .evict_data_i (evict_data_i),
    .req_ready_o  (req_ready_o),
    .fill_valid_o (fill_valid_o),
    .fill_data_o  (fill_data_o),
    .evict_done_o (evict_done_o),
    .err_o        (err_o),
    .mem_valid_o  (mem_valid_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_id_o     (mem_id_o),
    .mem_len_o    (mem_len_o),
    .mem_burst_o  (mem_burst_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_wstrb_o  (mem_wstrb_o),
    .mem_accept_i (mem_accept_i),
    .mem_bvalid_i (mem_bvalid_i),
    .mem_bresp_i  (mem_bresp_i),
    .mem_bready_o (mem_bready_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_rresp_i  (mem_rresp_i),
    .mem_rlast_i  (mem_rlast_i),
    .mem_rready_o (mem_rready_o)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_beat_t;

  typedef struct {
    bit           is_fill;
    logic [255:0] data;
    bit           err;
  } done_t;

  int           checks = 0;
  int           errors = 0;
  wr_beat_t     exp_wr[$];
  logic [31:0]  exp_rd[$];
  done_t        exp_done[$];
  logic [31:0]  model_line [8];

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s", name);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic sigSel(input int which);
    case (which)
      0:       return req_ready_o;
      1:       return mem_bready_o;
      default: return mem_rready_o;
    endcase
  endfunction

  task automatic waitFor(input int which, input string name);
    int n = 0;
    while (!sigSel(which) && n < 64) begin
      tick();
      n++;
    end
    if (!sigSel(which)) failNow(name);
  endtask

  function automatic logic [255:0] modelFlat();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = model_line[i];
    return v;
  endfunction

  // Cache side: wait until the engine is free and present a request for one cycle.
  task automatic applyStimulus(input bit do_fill, input bit do_evict,
                               input logic [31:0] addr, input logic [255:0] data);
    waitFor(0, "req_ready_timeout");
    fill_req_i   = do_fill;
    evict_req_i  = do_evict;
    req_addr_i   = addr;
    evict_data_i = data;
    tick();
    fill_req_i   = 1'b0;
    evict_req_i  = 1'b0;
  endtask

  // Full writeback: expected beats are the line words in order at the aligned address.
  task automatic runEvict(input logic [31:0] addr, input logic [255:0] data,
                          input int stall_beat, input int stall_cycles,
                          input bit rand_stall, input logic [1:0] bresp, input bit also_fill);
    done_t d;
    for (int i = 0; i < 8; i++) begin
      exp_wr.push_back('{addr & 32'hFFFF_FFE0, data[i*32 +: 32]});
      model_line[i] = data[i*32 +: 32];
    end
    d.is_fill = 1'b0;
    d.data    = '0;
    d.err     = (bresp != 2'b00);
    exp_done.push_back(d);
    applyStimulus(also_fill, 1'b1, addr, data);
    for (int b = 0; b < 8; b++) begin
      int st;
      st = (b == stall_beat) ? stall_cycles : (rand_stall ? int'($urandom_range(0, 2)) : 0);
      mem_accept_i = 1'b0;
      for (int k = 0; k < st; k++) begin
        tick();
        if (b == stall_beat) checkOutput("wdata_held_in_stall", mem_wdata_o, data[b*32 +: 32]);
      end
      mem_accept_i = 1'b1;
      tick();
    end
    mem_accept_i = 1'b0;
    waitFor(1, "bready_timeout");
    mem_bresp_i  = bresp;
    mem_bvalid_i = 1'b1;
    tick();
    mem_bvalid_i = 1'b0;
    mem_bresp_i  = 2'b00;
    tick();
    tick();
  endtask

  // Full or short refill; the model line keeps any word the burst never reached.
  task automatic runFill(input logic [31:0] addr, input logic [255:0] rdata,
                         input int nbeats, input logic [15:0] resps, input bit rand_gap);
    done_t d;
    d.err = (nbeats != 8);
    for (int i = 0; i < nbeats; i++) begin
      model_line[i] = rdata[i*32 +: 32];
      if (resps[i*2 +: 2] != 2'b00) d.err = 1'b1;
    end
    d.is_fill = 1'b1;
    d.data    = modelFlat();
    exp_rd.push_back(addr & 32'hFFFF_FFE0);
    exp_done.push_back(d);
    applyStimulus(1'b1, 1'b0, addr, '0);
    mem_accept_i = 1'b0;
    for (int k = 0; k < int'($urandom_range(0, 3)); k++) tick();
    mem_accept_i = 1'b1;
    tick();
    mem_accept_i = 1'b0;
    waitFor(2, "rready_timeout");
    for (int i = 0; i < nbeats; i++) begin
      if (rand_gap) begin
        for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
      end
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = rdata[i*32 +: 32];
      mem_rresp_i  = resps[i*2 +: 2];
      mem_rlast_i  = (i == nbeats - 1);
      tick();
      mem_rvalid_i = 1'b0;
      mem_rlast_i  = 1'b0;
      mem_rresp_i  = 2'b00;
    end
    tick();
    tick();
  endtask

  // Reset lands while the engine is holding beat 5 of a writeback.
  task automatic runEvictAbort(input logic [31:0] addr, input logic [255:0] data);
    for (int i = 0; i < 8; i++) exp_wr.push_back('{addr & 32'hFFFF_FFE0, data[i*32 +: 32]});
    applyStimulus(1'b0, 1'b1, addr, data);
    mem_accept_i = 1'b1;
    for (int b = 0; b < 5; b++) tick();
    mem_accept_i = 1'b0;
    checkOutput("abort_wdata_beat5", mem_wdata_o, data[5*32 +: 32]);
    rst = 1'b1;
    #1;
    exp_wr.delete();
    for (int i = 0; i < 8; i++) model_line[i] = '0;
    checkOutput("abort_mem_valid", mem_valid_o, 1'b0);
    checkOutput("abort_req_ready", req_ready_o, 1'b0);
    checkOutput("abort_wstrb", mem_wstrb_o, 4'h0);
    mem_bvalid_i = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checkOutput("abort_bready", mem_bready_o, 1'b0);
    checkOutput("abort_idle_ready", req_ready_o, 1'b1);
    tick();
    tick();
    mem_bvalid_i = 1'b0;
    checkOutput("abort_line_cleared", fill_data_o, '0);
  endtask

  // Monitor: every accepted request beat and every completion pulse is matched
  // against the oldest outstanding expectation.
  always @(negedge clk) begin
    wr_beat_t e;
    done_t    c;
    logic [31:0] ra;
    if (!rst) begin
      if (mem_valid_o && mem_accept_i) begin
        if (mem_write_o) begin
          if (exp_wr.size() == 0) begin
            failNow("unexpected_write_beat");
          end else begin
            e = exp_wr.pop_front();
            checkOutput("wr_addr", mem_addr_o, e.addr);
            checkOutput("wr_data", mem_wdata_o, e.data);
            checkOutput("wr_strb", mem_wstrb_o, 4'hF);
            checkOutput("wr_id", mem_id_o, TB_ID);
          end
        end else begin
          if (exp_rd.size() == 0) begin
            failNow("unexpected_read_request");
          end else begin
            ra = exp_rd.pop_front();
            checkOutput("rd_addr", mem_addr_o, ra);
            checkOutput("rd_len", mem_len_o, 8'd7);
            checkOutput("rd_burst", mem_burst_o, 2'b01);
            checkOutput("rd_id", mem_id_o, TB_ID);
            checkOutput("rd_strb", mem_wstrb_o, 4'h0);
          end
        end
      end
      if (fill_valid_o || evict_done_o) begin
        if (fill_valid_o && evict_done_o) begin
          failNow("both_completions_at_once");
        end else if (exp_done.size() == 0) begin
          failNow("unexpected_completion");
        end else begin
          c = exp_done.pop_front();
          checkOutput("done_is_fill", fill_valid_o, c.is_fill);
          checkOutput("done_err", err_o, c.err);
          if (c.is_fill) checkOutput("fill_data", fill_data_o, c.data);
        end
      end else if (err_o) begin
        failNow("err_without_completion");
      end
    end
  end

  // Directed scenarios first, then a randomized mix, then drain checks.
  initial begin
    logic [255:0] data;
    logic [15:0]  resps;
    int           nb;
    int           kind;

    rst = 1'b1;
    fill_req_i = 1'b0;  evict_req_i = 1'b0;
    req_addr_i = '0;    evict_data_i = '0;
    mem_accept_i = 1'b0; mem_bvalid_i = 1'b0; mem_bresp_i = 2'b00;
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;    mem_rresp_i = 2'b00; mem_rlast_i = 1'b0;
    for (int i = 0; i < 8; i++) model_line[i] = '0;
    tick();
    tick();
    checkOutput("rst_req_ready", req_ready_o, 1'b0);
    checkOutput("rst_mem_valid", mem_valid_o, 1'b0);
    checkOutput("rst_mem_len", mem_len_o, 8'd7);
    checkOutput("rst_mem_burst", mem_burst_o, 2'b01);
    checkOutput("rst_mem_id", mem_id_o, TB_ID);
    checkOutput("rst_fill_data", fill_data_o, '0);
    checkOutput("rst_pulses", {fill_valid_o, evict_done_o, err_o}, 3'b000);
    checkOutput("rst_readies", {mem_bready_o, mem_rready_o}, 2'b00);
    checkOutput("rst_mem_addr", mem_addr_o, 32'h0);
    rst = 1'b0;
    tick();
    checkOutput("idle_req_ready", req_ready_o, 1'b1);

    $display("[TB] evict words 0..7, accept always high");
    for (int i = 0; i < 8; i++) data[i*32 +: 32] = i;
    runEvict(32'h1234_5678, data, -1, 0, 1'b0, 2'b00, 1'b0);

    $display("[TB] evict with 3-cycle stall on beat 4");
    for (int i = 0; i < 8; i++) data[i*32 +: 32] = 32'hC0DE_0100 + i;
    runEvict(32'h0000_4020, data, 4, 3, 1'b0, 2'b00, 1'b0);

    $display("[TB] fill at 0x8000_0010");
    for (int i = 0; i < 8; i++) data[i*32 +: 32] = 32'hA0 + i;
    runFill(32'h8000_0010, data, 8, 16'h0000, 1'b0);

    $display("[TB] simultaneous fill and evict");
    for (int i = 0; i < 8; i++) data[i*32 +: 32] = $urandom;
    runEvict(32'h7777_7777, data, -1, 0, 1'b1, 2'b00, 1'b1);

    $display("[TB] fill with SLVERR on beat 3");
    for (int i = 0; i < 8; i++) data[i*32 +: 32] = $urandom;
    resps = 16'h0080;
    runFill(32'h0001_0040, data, 8, resps, 1'b1);

    $display("[TB] write response error, stray rvalid in idle, short fill");
    for (int i = 0; i < 8; i++) data[i*32 +: 32] = $urandom;
    runEvict(32'h0002_0000, data, -1, 0, 1'b0, 2'b10, 1'b0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF; mem_rlast_i = 1'b1;
    tick();
    checkOutput("idle_rready", mem_rready_o, 1'b0);
    tick();
    mem_rvalid_i = 1'b0; mem_rlast_i = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) data[i*32 +: 32] = $urandom;
    runFill(32'h0003_00E4, data, 5, 16'h0000, 1'b0);

    $display("[TB] reset during writeback beat 5");
    for (int i = 0; i < 8; i++) data[i*32 +: 32] = 32'h5000_0000 + i;
    runEvictAbort(32'h0004_0000, data);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 24; t++) begin
      kind = int'($urandom_range(0, 2));
      for (int i = 0; i < 8; i++) data[i*32 +: 32] = $urandom;
      if (kind == 1) begin
        nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 8;
        for (int i = 0; i < 8; i++) resps[i*2 +: 2] = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        runFill($urandom, data, nb, resps, 1'b1);
      end else begin
        runEvict($urandom, data, -1, 0, 1'b1,
                 ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, kind == 2);
      end
    end

    for (int k = 0; k < 4; k++) tick();
    checkOutput("drain_wr", 32'(exp_wr.size()), 32'd0);
    checkOutput("drain_rd", 32'(exp_rd.size()), 32'd0);
    checkOutput("drain_done", 32'(exp_done.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute safety net so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] global timeout");
  end

endmodule
